// File: rtl/pc_fetch.sv
// Fetch stage: program counter driving the ROM address, plus the stage-2
// instruction register with its valid flag, source address and accept count.
module pc_fetch (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] D_BUS,
    input  logic       load,
    input  logic       hold,
    output logic [3:0] A_BUS,
    output logic [7:0] IR,
    output logic       ir_valid,
    output logic [3:0] ir_pc,
    output logic [7:0] fetch_cnt
);

    logic [3:0] pc_q,    pc_d;
    logic [7:0] ir_q,    ir_d;
    logic       valid_q, valid_d;
    logic [3:0] ir_pc_q, ir_pc_d;
    logic [7:0] cnt_q,   cnt_d;

    // Load beats hold: the jump pulse lasts one cycle and must not be dropped.
    // The jump target is the immediate of the instruction already sitting in IR,
    // and the wrong-path word on D_BUS is replaced by a bubble.
    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        valid_d = valid_q;
        ir_pc_d = ir_pc_q;
        cnt_d   = cnt_q;
        if (load) begin
            pc_d    = ir_q[3:0];
            ir_d    = 8'h00;
            valid_d = 1'b0;
        end else if (!hold) begin
            ir_d    = D_BUS;
            ir_pc_d = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 4'd1;
            cnt_d   = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q    <= 4'h0;
            ir_q    <= 8'h00;
            valid_q <= 1'b0;
            ir_pc_q <= 4'h0;
            cnt_q   <= 8'h00;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            valid_q <= valid_d;
            ir_pc_q <= ir_pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign A_BUS     = pc_q;
    assign IR        = ir_q;
    assign ir_valid  = valid_q;
    assign ir_pc     = ir_pc_q;
    assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: a ROM model feeds D_BUS from A_BUS, and a
// reference model plus hand-computed vector table predict every output.
module tb_pc_fetch;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] D_BUS;
    logic       load;
    logic       hold;
    logic [3:0] A_BUS;
    logic [7:0] IR;
    logic       ir_valid;
    logic [3:0] ir_pc;
    logic [7:0] fetch_cnt;

    logic [7:0] rom [16];
    logic       dOvr;
    logic [7:0] dVal;

    typedef struct {
        logic [3:0] a;
        logic [7:0] ir;
        logic       v;
        logic [3:0] irPc;
        logic [7:0] cnt;
    } outs_t;

    typedef struct {
        logic       ld;
        logic       hd;
        logic       ovr;
        logic [7:0] dv;
        outs_t      exp;
    } vec_t;

    outs_t sbQueue[$];
    vec_t  tbl[11];
    outs_t noExp;
    int    total = 0;
    int    bad   = 0;

    logic [3:0] mPc;
    logic [7:0] mIr;
    logic       mValid;
    logic [3:0] mIrPc;
    logic [7:0] mCnt;

    pc_fetch dut (
        .clock     (clock),
        .reset     (reset),
        .D_BUS     (D_BUS),
        .load      (load),
        .hold      (hold),
        .A_BUS     (A_BUS),
        .IR        (IR),
        .ir_valid  (ir_valid),
        .ir_pc     (ir_pc),
        .fetch_cnt (fetch_cnt)
    );

    always #5 clock = ~clock;

    // ROM answers the address the DUT presents unless a test forces a wrong-path word
    assign D_BUS = dOvr ? dVal : rom[A_BUS];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic compareAll(input string tag, input outs_t e);
        checkOutput({tag, ".A_BUS"},     {4'h0, A_BUS},    {4'h0, e.a});
        checkOutput({tag, ".IR"},        IR,               e.ir);
        checkOutput({tag, ".ir_valid"},  {7'h0, ir_valid}, {7'h0, e.v});
        checkOutput({tag, ".ir_pc"},     {4'h0, ir_pc},    {4'h0, e.irPc});
        checkOutput({tag, ".fetch_cnt"}, fetch_cnt,        e.cnt);
    endtask

    task automatic modelReset();
        mPc = 4'h0; mIr = 8'h00; mValid = 1'b0; mIrPc = 4'h0; mCnt = 8'h00;
    endtask

    task automatic modelStep(input logic ld, input logic hd, input logic [7:0] d);
        if (ld) begin
            mPc    = mIr[3:0];
            mIr    = 8'h00;
            mValid = 1'b0;
        end else if (!hd) begin
            mIr    = d;
            mIrPc  = mPc;
            mValid = 1'b1;
            mPc    = mPc + 4'd1;
            mCnt   = mCnt + 8'd1;
        end
    endtask

    function automatic outs_t modelOuts();
        outs_t o;
        o.a = mPc; o.ir = mIr; o.v = mValid; o.irPc = mIrPc; o.cnt = mCnt;
        return o;
    endfunction

    function automatic vec_t mkVec(input logic ld, input logic hd, input logic ovr, input logic [7:0] dv,
                                   input logic [3:0] a, input logic [7:0] ir, input logic v,
                                   input logic [3:0] irPc, input logic [7:0] cnt);
        vec_t r;
        r.ld = ld; r.hd = hd; r.ovr = ovr; r.dv = dv;
        r.exp.a = a; r.exp.ir = ir; r.exp.v = v; r.exp.irPc = irPc; r.exp.cnt = cnt;
        return r;
    endfunction

    // One clock edge: drive inputs, queue the expectation, compare after the edge
    task automatic applyStimulus(input logic ld, input logic hd, input logic ovr, input logic [7:0] dv,
                                 input logic useExp, input outs_t tExp, input string tag);
        logic [7:0] d;
        load = ld; hold = hd; dOvr = ovr; dVal = dv;
        d = ovr ? dv : rom[mPc];
        modelStep(ld, hd, d);
        if (useExp) sbQueue.push_back(tExp);
        else        sbQueue.push_back(modelOuts());
        @(posedge clock);
        #1;
        compareAll(tag, sbQueue.pop_front());
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".A_BUS"},     {4'h0, A_BUS},    8'h00);
        checkOutput({tag, ".IR"},        IR,               8'h00);
        checkOutput({tag, ".ir_valid"},  {7'h0, ir_valid}, 8'h00);
        checkOutput({tag, ".ir_pc"},     {4'h0, ir_pc},    8'h00);
        checkOutput({tag, ".fetch_cnt"}, fetch_cnt,        8'h00);
    endtask

    initial begin
        noExp = '{default: '0};
        for (int i = 0; i < 16; i++) rom[i] = 8'h10 + 8'(i);
        reset = 1'b0; load = 1'b0; hold = 1'b0; dOvr = 1'b0; dVal = 8'h00;
        modelReset();

        repeat (2) @(posedge clock);
        #1;
        checkResetValues("reset");
        reset = 1'b1;

        // Straight-line run through the A_BUS wrap
        for (int i = 0; i < 17; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, noExp, "run");
        checkOutput("run.final_cnt", fetch_cnt, 8'd17);
        checkOutput("run.final_a", {4'h0, A_BUS}, 8'h01);

        // Jump, bubble, second jump to 5, then a three-cycle hold
        rom[3]    = 8'hF9;
        rom[4'hA] = 8'hE5;
        tbl[0]  = mkVec(0, 0, 0, 8'h00, 4'h2, 8'h11, 1, 4'h1, 8'h12);
        tbl[1]  = mkVec(0, 0, 0, 8'h00, 4'h3, 8'h12, 1, 4'h2, 8'h13);
        tbl[2]  = mkVec(0, 0, 0, 8'h00, 4'h4, 8'hF9, 1, 4'h3, 8'h14);
        tbl[3]  = mkVec(1, 0, 1, 8'hAA, 4'h9, 8'h00, 0, 4'h3, 8'h14);
        tbl[4]  = mkVec(0, 0, 0, 8'h00, 4'hA, 8'h19, 1, 4'h9, 8'h15);
        tbl[5]  = mkVec(0, 0, 0, 8'h00, 4'hB, 8'hE5, 1, 4'hA, 8'h16);
        tbl[6]  = mkVec(1, 0, 0, 8'h00, 4'h5, 8'h00, 0, 4'hA, 8'h16);
        tbl[7]  = mkVec(0, 1, 0, 8'h00, 4'h5, 8'h00, 0, 4'hA, 8'h16);
        tbl[8]  = mkVec(0, 1, 0, 8'h00, 4'h5, 8'h00, 0, 4'hA, 8'h16);
        tbl[9]  = mkVec(0, 1, 0, 8'h00, 4'h5, 8'h00, 0, 4'hA, 8'h16);
        tbl[10] = mkVec(0, 0, 0, 8'h00, 4'h6, 8'h15, 1, 4'h5, 8'h17);
        for (int i = 0; i < 11; i++)
            applyStimulus(tbl[i].ld, tbl[i].hd, tbl[i].ovr, tbl[i].dv, 1'b1, tbl[i].exp, $sformatf("tbl%0d", i));

        // Load together with hold, then a load straight after the bubble
        rom[6] = 8'hE2;
        rom[0] = 8'hF1;
        rom[1] = 8'hFF;
        rom[4'hF] = 8'hF0;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, noExp, "fetchE2");
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, noExp, "loadHold");
        checkOutput("loadHold.target", {4'h0, A_BUS}, 8'h02);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, noExp, "loadBubble");
        checkOutput("loadBubble.target", {4'h0, A_BUS}, 8'h00);

        // Jump whose target equals the current A_BUS still bubbles
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, noExp, "fetchF1");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, noExp, "selfJump");
        checkOutput("selfJump.valid", {7'h0, ir_valid}, 8'h00);

        // Back-to-back: jump to F, whose instruction jumps to 0
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, noExp, "fetchFF");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, noExp, "jumpF");
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, noExp, "fetchF0");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, noExp, "jump0");
        checkOutput("jump0.a", {4'h0, A_BUS}, 8'h00);
        checkOutput("jump0.irpc", {4'h0, ir_pc}, 8'h0F);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, noExp, "afterJump0");

        // Long run across the fetch_cnt wrap, then random load/hold traffic
        for (int i = 0; i < 260; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, noExp, "wrap");
        for (int i = 0; i < 60; i++)
            applyStimulus(($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0), 1'b0, 8'h00,
                          1'b0, noExp, "rand");

        // Reset between edges while holding at A_BUS=C
        for (int i = 0; i < 16 && mPc != 4'hC; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, noExp, "seekC");
        checkOutput("seekC.a", {4'h0, A_BUS}, 8'h0C);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, noExp, "holdC");
        #2 reset = 1'b0;
        #1 checkResetValues("asyncHold");
        modelReset();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, noExp, "firstFetch");

        // Reset while a load pulse is pending; the pulse must not survive
        load = 1'b1;
        #2 reset = 1'b0;
        #1 checkResetValues("asyncLoad");
        modelReset();
        load = 1'b0;
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, noExp, "postLoadReset");
        checkOutput("postLoadReset.ir", IR, 8'hF1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
